jtframe_mixer_seq: RTL and testbench
====================================

Name: jtframe_mixer_seq

Overview:
- Time-multiplexed N-channel audio mixer. One multiplier is shared across all channels, so wide channel counts stay cheap in DSP blocks.
- On each sample strobe it snapshots every channel and gain, then accumulates one channel per clock. It outputs a saturated, registered mix with valid, peak and overrun status.
- Sits between the per-chip sound cores and the final frame audio output.
- Generalises the fixed 4-channel combinational mixer with:
  - parametrised channel count;
  - a common, parametrised input width;
  - clipping reporting.

Parameters:
- CH, 4, number of channels (2..16)
- W, 16, width of every input channel, signed (8..16)
- WOUT, 16, output width, signed; must satisfy WOUT <= W
- GFRAC, 4, fractional bits of the 8-bit unsigned gain (4 gives 4.4 format)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cen  in  1  sample strobe, one-cycle pulse; starts a mix
- ch  in  CH*W  packed signed channels; channel k is ch[k*W +: W]
- gain  in  CH*8  packed unsigned gains; gain k is gain[k*8 +: 8], GFRAC fractional bits
- mixed  out  WOUT  signed mixed sample, registered
- valid  out  1  one-cycle pulse when mixed updates
- peak  out  1  high for the same cycle as valid if the sample saturated
- busy  out  1  high while a mix is in progress
- overrun  out  1  sticky; cen arrived while busy

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on posedge clk.
  - rst is synchronous and active-high, and has priority over everything else.
  - rst clears mixed, valid, peak, busy, overrun, the accumulator and the channel index, and sets the state to IDLE.
  - rst asserted mid-mix abandons the mix; no valid is produced for it.
- State machine: IDLE, ACC, DONE.
- IDLE:
  - busy=0.
  - On cen: latch ch and gain into snapshot registers, clear the accumulator, set idx=0, go to ACC.
- ACC:
  - busy=1.
  - Each cycle: acc <= acc + ({1'b0,gain[idx]} * ch[idx]), computed signed, using snapshot values only.
  - The product is W+9 bits; the accumulator is W+9+clog2(CH) bits, so it cannot overflow internally.
  - idx increments each cycle. After idx==CH-1 is added, go to DONE.
- DONE:
  - busy=1 for this cycle.
  - Compute s = acc >>> GFRAC (arithmetic shift).
  - Saturate s to a W-bit signed range [-(2^(W-1)), 2^(W-1)-1].
  - mixed <= sat[W-1 -: WOUT], i.e. truncation, no rounding.
  - valid <= 1 for one cycle.
  - peak <= 1 for that same cycle if saturation clipped, else 0.
  - Return to IDLE.
- Latency: cen in cycle t gives valid in cycle t+CH+2. Precisely:
  - latch at edge t;
  - ACC edges t+1..t+CH;
  - DONE edge t+CH+1;
  - valid visible during t+CH+2.
- Output holding: mixed holds its value between valid pulses. valid and peak are 0 outside their pulse.
- cen while busy (ACC or DONE):
  - The strobe is ignored and the snapshot is untouched.
  - overrun <= 1 and stays 1 until rst.
- cen in the same cycle the FSM returns to IDLE (i.e. the cycle valid is high): accepted normally.
- Input independence: inputs may change freely after the latch cycle without affecting the current mix.
- Gain range: gain 0 contributes 0. Gain 0xFF with GFRAC=4 multiplies by 15.9375.
- Channel scaling: all channels share W bits. Narrower sources are left-aligned by the instantiating core before connection.
- Simulation checks: a parameter check under SIMULATION reports and finishes if WOUT>W, CH<2 or CH>16.

Test Plan:
- CH=4, W=WOUT=16, GFRAC=4; ch0=0x1000, gain0=0x10, other gains 0; pulse cen → valid exactly 6 cycles later, mixed=0x1000, peak=0.
- ch0=0x1000, gain0=0x20; ch1=0xF000 (-4096), gain1=0x08; others 0 → mixed=0x2000-0x0800=0x1800, peak=0.
- All four channels 0x7000, gains 0x10 → mixed=0x7FFF, peak=1. Repeat with all channels 0x8000 → mixed=0x8000, peak=1.
- WOUT=8, ch0=0x1234, gain0=0x10 → mixed=0x12. Then a second cen issued in the valid cycle → second valid 6 cycles after it, overrun=0.
- cen pulsed again 2 cycles after the first → first result unchanged, overrun=1 and stays 1 across later mixes until rst.
- rst asserted during ACC → next cycle mixed=0, busy=0, no valid pulse. A following cen produces a correct mix from fresh inputs.

Source files
------------

// File: rtl/jtframe_mixer_seq.sv
// Time-multiplexed N-channel audio mixer: snapshots all channels on cen, then
// accumulates one gain-scaled channel per clock through a single shared multiplier.
module jtframe_mixer_seq #(
  parameter int CH    = 4,
  parameter int W     = 16,
  parameter int WOUT  = 16,
  parameter int GFRAC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [CH*W-1:0]   ch,
  input  logic [CH*8-1:0]   gain,
  output logic [WOUT-1:0]   mixed,
  output logic              valid,
  output logic              peak,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned CW = $clog2(CH);
  localparam int unsigned IW = (CW < 1) ? 1 : CW;
  localparam int unsigned PW = W + 9;
  localparam int unsigned AW = W + 9 + CW;

`ifdef SIMULATION
  if (WOUT > W || CH < 2 || CH > 16) begin : g_param_check
    $fatal(1, "jtframe_mixer_seq: bad parameters CH=%0d W=%0d WOUT=%0d", CH, W, WOUT);
  end
`endif

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic signed [AW-1:0]  acc;
  logic signed [W-1:0]   ch_s [CH];
  logic [7:0]            g_s  [CH];

  logic signed [PW-1:0]  prod_c;
  logic signed [AW-1:0]  shifted_c;
  logic signed [W-1:0]   sat_c;
  logic                  clip_c;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    prod_c = PW'($signed({1'b0, g_s[idx]})) * PW'(ch_s[idx]);
  end

  // Scale back by the gain fraction, then clamp to the W-bit signed range.
  always_comb begin
    shifted_c = acc >>> GFRAC;
    sat_c     = shifted_c[W-1:0];
    clip_c    = 1'b0;
    if (shifted_c > AW'($signed({1'b0, {(W-1){1'b1}}}))) begin
      sat_c  = {1'b0, {(W-1){1'b1}}};
      clip_c = 1'b1;
    end else if (shifted_c < AW'($signed({1'b1, {(W-1){1'b0}}}))) begin
      sat_c  = {1'b1, {(W-1){1'b0}}};
      clip_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= '0;
      mixed   <= '0;
      valid   <= 1'b0;
      peak    <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid <= 1'b0;
      peak  <= 1'b0;
      case (state)
        IDLE: begin
          if (cen) begin
            for (int k = 0; k < CH; k++) begin
              ch_s[k] <= ch[k*W +: W];
              g_s[k]  <= gain[k*8 +: 8];
            end
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ACC;
          end
        end
        ACC: begin
          if (cen) overrun <= 1'b1;
          acc <= acc + AW'(prod_c);
          idx <= idx + IW'(1);
          if (idx == IW'(CH - 1)) state <= DONE;
        end
        DONE: begin
          if (cen) overrun <= 1'b1;
          mixed <= sat_c[W-1 -: WOUT];
          valid <= 1'b1;
          peak  <= clip_c;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_mixer_seq.sv
// Directed self-checking bench for jtframe_mixer_seq (CH=4, W=16, GFRAC=4),
// with a second WOUT=8 instance sharing the same stimulus.
module tb_jtframe_mixer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [63:0] ch;
  logic [31:0] gain;

  logic [15:0] mixed;
  logic        valid, peak, busy, overrun;
  logic [7:0]  mixed8;
  logic        valid8, peak8, busy8, overrun8;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  jtframe_mixer_seq #(.CH(4), .W(16), .WOUT(16), .GFRAC(4)) dut (
    .clk(clk), .rst(rst), .cen(cen), .ch(ch), .gain(gain),
    .mixed(mixed), .valid(valid), .peak(peak), .busy(busy), .overrun(overrun)
  );

  jtframe_mixer_seq #(.CH(4), .W(16), .WOUT(8), .GFRAC(4)) dut8 (
    .clk(clk), .rst(rst), .cen(cen), .ch(ch), .gain(gain),
    .mixed(mixed8), .valid(valid8), .peak(peak8), .busy(busy8), .overrun(overrun8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_in(input int k, input logic [15:0] v, input logic [7:0] g);
    ch[k*16 +: 16] = v;
    gain[k*8 +: 8] = g;
  endtask

  task automatic clr_in();
    ch   = '0;
    gain = '0;
  endtask

  // Counts negedges until valid shows, bounded so a dead DUT cannot hang the run.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (valid !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic pulse_cen();
    cen = 1'b1;
    tick();
    cen = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; clr_in();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_mixed", mixed, 16'h0000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);

    // Unity gain on channel 0; the other channels carry data at gain 0
    set_in(0, 16'h1000, 8'h10);
    set_in(1, 16'h7FFF, 8'h00);
    set_in(2, 16'h8000, 8'h00);
    pulse_cen();
    clr_in();
    chk("t1_busy", busy, 1'b1);
    wait_valid(n);
    chk("t1_latency", n, 5);
    chk("t1_mixed", mixed, 16'h1000);
    chk("t1_peak", peak, 1'b0);
    tick();
    chk("t1_valid_drop", valid, 1'b0);
    chk("t1_hold", mixed, 16'h1000);
    chk("t1_busy_idle", busy, 1'b0);

    // 2.0*0x1000 + 0.5*(-0x1000)
    set_in(0, 16'h1000, 8'h20);
    set_in(1, 16'hF000, 8'h08);
    pulse_cen();
    clr_in();
    wait_valid(n);
    chk("t2_latency", n, 5);
    chk("t2_mixed", mixed, 16'h1800);
    chk("t2_peak", peak, 1'b0);
    tick();

    // Positive and negative saturation
    for (int k = 0; k < 4; k++) set_in(k, 16'h7000, 8'h10);
    pulse_cen();
    wait_valid(n);
    chk("t3_mixed_pos", mixed, 16'h7FFF);
    chk("t3_peak_pos", peak, 1'b1);
    tick();
    chk("t3_peak_drop", peak, 1'b0);
    for (int k = 0; k < 4; k++) set_in(k, 16'h8000, 8'h10);
    pulse_cen();
    clr_in();
    wait_valid(n);
    chk("t3_mixed_neg", mixed, 16'h8000);
    chk("t3_peak_neg", peak, 1'b1);
    tick();

    // -1/16 floors to -1 under arithmetic shift
    set_in(0, 16'hFFFF, 8'h01);
    pulse_cen();
    clr_in();
    wait_valid(n);
    chk("t4_mixed_neg1", mixed, 16'hFFFF);
    chk("t4_mixed8_neg1", mixed8, 8'hFF);
    chk("t4_peak", peak, 1'b0);
    tick();

    // Narrow output truncates; back-to-back cen in the valid cycle is accepted
    set_in(0, 16'h1234, 8'h10);
    pulse_cen();
    clr_in();
    wait_valid(n);
    chk("t5_valid8", valid8, 1'b1);
    chk("t5_mixed8", mixed8, 8'h12);
    chk("t5_mixed16", mixed, 16'h1234);
    set_in(0, 16'h0100, 8'h30);
    pulse_cen();
    clr_in();
    wait_valid(n);
    chk("t5_b2b_latency", n, 5);
    chk("t5_b2b_mixed", mixed, 16'h0300);
    chk("t5_b2b_mixed8", mixed8, 8'h03);
    chk("t5_overrun", overrun, 1'b0);
    chk("t5_overrun8", overrun8, 1'b0);
    tick();

    // Second cen two cycles into a mix is ignored but flagged
    set_in(0, 16'h0200, 8'h10);
    pulse_cen();
    clr_in();
    tick();
    set_in(0, 16'h7FFF, 8'hFF);
    pulse_cen();
    clr_in();
    wait_valid(n);
    chk("t6_latency", n, 3);
    chk("t6_mixed", mixed, 16'h0200);
    chk("t6_overrun", overrun, 1'b1);
    tick();
    set_in(3, 16'h0040, 8'h10);
    pulse_cen();
    clr_in();
    wait_valid(n);
    chk("t6_next_mixed", mixed, 16'h0040);
    chk("t6_overrun_sticky", overrun, 1'b1);
    tick();

    // Reset mid-accumulation abandons the mix
    set_in(0, 16'h3000, 8'h10);
    pulse_cen();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_mixed", mixed, 16'h0000);
    chk("t7_busy", busy, 1'b0);
    chk("t7_overrun", overrun, 1'b0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid === 1'b1) n++;
      tick();
    end
    chk("t7_no_valid", n, 0);
    clr_in();
    set_in(1, 16'h0400, 8'h08);
    pulse_cen();
    clr_in();
    wait_valid(n);
    chk("t7_fresh_latency", n, 5);
    chk("t7_fresh_mixed", mixed, 16'h0200);
    chk("t7_fresh_peak", peak, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
